// File: rtl/pulse_train_gen_pkg.sv
// Shared defaults and per-channel FSM state encoding for the pulse train generator.
package pulse_train_gen_pkg;

  localparam int unsigned CH_NUM_DEF = 4;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned PER_W_DEF  = 8;

  // Shortest legal period: one HIGH cycle plus at least one LOW cycle.
  localparam int unsigned PER_MIN    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } emit_state_e;

endpackage

// File: rtl/pulse_train_gen_emitter.sv
// Single-channel pulse emitter: N one-cycle pulses spaced P clocks apart.
module pulse_emitter
  import pulse_train_gen_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned PER_W = PER_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [CNT_W-1:0] i_pulse_num,
  input  logic [PER_W-1:0] i_period,
  output logic             o_pulse,
  output logic             o_busy,
  output logic             o_done
);

  emit_state_e      state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;   // pulses still to emit, including the current HIGH
  logic [PER_W-1:0] per_q, per_d;   // latched effective period
  logic [PER_W-1:0] gap_q, gap_d;   // LOW cycles left before the next HIGH
  logic             done_q, done_d;
  logic [PER_W-1:0] per_eff;

  // Clamp the requested period so every pulse is followed by at least one LOW cycle.
  always_comb begin
    per_eff = i_period;
    if (i_period < PER_W'(PER_MIN)) per_eff = PER_W'(PER_MIN);
  end

  // Next-state: stop wins over everything; otherwise progress only while enabled.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    per_d   = per_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    if (i_stop) begin
      state_d = IDLE;
    end else if (i_en) begin
      unique case (state_q)
        IDLE: begin
          if (i_start && (i_pulse_num != '0)) begin
            state_d = HIGH;
            rem_d   = i_pulse_num;
            per_d   = per_eff;
          end
        end
        HIGH: begin
          if (rem_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            rem_d   = rem_q - 1'b1;
            gap_d   = per_q - 1'b1;
            state_d = LOW;
          end
        end
        LOW: begin
          if (gap_q == PER_W'(1)) state_d = HIGH;
          else                    gap_d   = gap_q - 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      per_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      per_q   <= per_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end

  // A HIGH held across a disabled stretch stays pending and is shown once enable returns.
  assign o_pulse = (state_q == HIGH) && i_en;
  assign o_busy  = (state_q != IDLE);
  assign o_done  = done_q;

endmodule

// File: rtl/pulse_train_gen.sv
// Multi-channel pulse train generator: slices packed request buses into per-channel emitters.
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int unsigned CH_NUM = CH_NUM_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned PER_W  = PER_W_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic [CH_NUM-1:0]       i_start,
  input  logic [CH_NUM-1:0]       i_stop,
  input  logic [CH_NUM*CNT_W-1:0] i_pulse_num,
  input  logic [CH_NUM*PER_W-1:0] i_period,
  output logic [CH_NUM-1:0]       o_pulse,
  output logic [CH_NUM-1:0]       o_busy,
  output logic [CH_NUM-1:0]       o_done
);

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    pulse_emitter #(
      .CNT_W(CNT_W),
      .PER_W(PER_W)
    ) u_emit (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_en       (i_en),
      .i_start    (i_start[g]),
      .i_stop     (i_stop[g]),
      .i_pulse_num(i_pulse_num[g*CNT_W +: CNT_W]),
      .i_period   (i_period[g*PER_W +: PER_W]),
      .o_pulse    (o_pulse[g]),
      .o_busy     (o_busy[g]),
      .o_done     (o_done[g])
    );
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: directed scenarios, cycle-by-cycle model compare, literal timelines.
module tb_pulse_train_gen;

  localparam int CH = 4;
  localparam int CW = 16;
  localparam int PW = 8;

  logic            clk = 1'b0;
  logic            i_rst, i_en;
  logic [CH-1:0]   i_start, i_stop;
  logic [CH*CW-1:0] i_pulse_num;
  logic [CH*PW-1:0] i_period;
  logic [CH-1:0]   o_pulse, o_busy, o_done;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_on  = 1'b0;

  logic [63:0] pm [CH];
  logic [63:0] bm [CH];
  logic [63:0] dm [CH];

  always #5 clk = ~clk;

  pulse_train_gen #(
    .CH_NUM(CH),
    .CNT_W (CW),
    .PER_W (PW)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_pulse_num(i_pulse_num),
    .i_period   (i_period),
    .o_pulse    (o_pulse),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Model: a train is "k enabled cycles since start"; a pulse falls on every multiple of P.
  bit act_m [CH];
  bit dn_m  [CH];
  int k_m   [CH];
  int n_m   [CH];
  int p_m   [CH];

  always @(negedge clk) begin
    if (chk_on) begin
      for (int c = 0; c < CH; c++) begin
        bit ep;
        int num, per;
        ep = act_m[c] && i_en && (k_m[c] % p_m[c] == 0);
        chk($sformatf("model_pulse_ch%0d", c), 64'(o_pulse[c]), 64'(ep));
        chk($sformatf("model_busy_ch%0d", c),  64'(o_busy[c]),  64'(act_m[c]));
        chk($sformatf("model_done_ch%0d", c),  64'(o_done[c]),  64'(dn_m[c]));
        num = int'(i_pulse_num[c*CW +: CW]);
        per = int'(i_period[c*PW +: PW]);
        if (i_rst) begin
          act_m[c] = 0; dn_m[c] = 0; k_m[c] = 0;
        end else if (i_stop[c]) begin
          act_m[c] = 0; dn_m[c] = 0;
        end else if (act_m[c]) begin
          dn_m[c] = 0;
          if (i_en) begin
            if ((k_m[c] % p_m[c] == 0) && (k_m[c] / p_m[c] == n_m[c] - 1)) begin
              act_m[c] = 0; dn_m[c] = 1;
            end else begin
              k_m[c]++;
            end
          end
        end else begin
          dn_m[c] = 0;
          if (i_start[c] && i_en && num != 0) begin
            act_m[c] = 1; k_m[c] = 0; n_m[c] = num;
            p_m[c] = (per < 2) ? 2 : per;
          end
        end
      end
    end
  end

  task automatic set_cfg(input int c, input int n, input int p);
    i_pulse_num[c*CW +: CW] = CW'(n);
    i_period[c*PW +: PW]    = PW'(p);
  endtask

  // Entered just after a rising edge; offset 0 is the cycle in which starts are first driven.
  task automatic run(input int n, input logic [63:0] st_offs, input logic [CH-1:0] st,
                     input int en_lo_at, input int en_lo_len,
                     input int stop_at, input logic [CH-1:0] stop_m, input int rst_at);
    for (int c = 0; c < CH; c++) begin pm[c] = '0; bm[c] = '0; dm[c] = '0; end
    for (int o = 0; o < n; o++) begin
      i_start = st_offs[o] ? st : '0;
      i_en    = !(o >= en_lo_at && o < en_lo_at + en_lo_len);
      i_stop  = (o == stop_at) ? stop_m : '0;
      i_rst   = (o == rst_at);
      if (o == 1 && st_offs == 64'h1) begin
        i_pulse_num = {CH{16'd1}};
        i_period    = {CH{8'd9}};
      end
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        pm[c][o] = o_pulse[c];
        bm[c][o] = o_busy[c];
        dm[c][o] = o_done[c];
      end
      @(posedge clk); #1;
    end
    i_start = '0; i_stop = '0; i_en = 1'b1; i_rst = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_en = 1'b1; i_start = '0; i_stop = '0;
    i_pulse_num = '0; i_period = '0;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    chk_on = 1'b1;
    chk("reset_pulse", 64'(o_pulse), 64'h0);
    chk("reset_busy",  64'(o_busy),  64'h0);
    chk("reset_done",  64'(o_done),  64'h0);

    // Basic train, with request inputs scrambled after the start is taken.
    set_cfg(0, 3, 4);
    run(16, 64'h1, 4'b0001, -1, 0, -1, '0, -1);
    chk("n3p4_pulses", pm[0], 64'h222);
    chk("n3p4_busy",   bm[0], 64'h3FE);
    chk("n3p4_done",   dm[0], 64'h400);

    // N=0 ignored; P=0 and P=1 clamp to 2.
    set_cfg(1, 0, 4); set_cfg(2, 2, 0); set_cfg(3, 2, 1);
    run(8, 64'h1, 4'b1110, -1, 0, -1, '0, -1);
    chk("n0_activity", pm[1] | bm[1] | dm[1], 64'h0);
    chk("p0_pulses",   pm[2], 64'hA);
    chk("p0_done",     dm[2], 64'h10);
    chk("p1_pulses",   pm[3], 64'hA);

    // Start while disabled is ignored.
    set_cfg(0, 2, 3);
    run(8, 64'h1, 4'b0001, 0, 1, -1, '0, -1);
    chk("start_en_low", pm[0] | bm[0] | dm[0], 64'h0);

    // Four independent trains, N=1..4, P=3.
    for (int c = 0; c < CH; c++) set_cfg(c, c + 1, 3);
    run(16, 64'h1, 4'b1111, -1, 0, -1, '0, -1);
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("count_ch%0d", c), 64'($countones(pm[c])), 64'(c + 1));
      chk($sformatf("donecnt_ch%0d", c), 64'($countones(dm[c])), 64'h1);
    end
    chk("ch3_pulses", pm[3], 64'h492);
    chk("ch3_done",   dm[3], 64'h800);

    // Enable low for 5 cycles in the second gap.
    set_cfg(0, 3, 4);
    run(24, 64'h1, 4'b0001, 6, 5, -1, '0, -1);
    chk("pause_pulses", pm[0], 64'h4022);
    chk("pause_done",   dm[0], 64'h8000);

    // Stop after the second pulse.
    set_cfg(2, 5, 4);
    run(30, 64'h1, 4'b0100, -1, 0, 6, 4'b0100, -1);
    chk("stop_pulses", pm[2], 64'h22);
    chk("stop_busy",   bm[2], 64'h7E);
    chk("stop_done",   dm[2], 64'h0);

    // Reset mid-train.
    set_cfg(3, 4, 3);
    run(12, 64'h1, 4'b1000, -1, 0, -1, '0, 3);
    chk("rst_pulses", pm[3], 64'h2);
    chk("rst_busy",   bm[3], 64'hE);
    chk("rst_done",   dm[3], 64'h0);
    chk("rst_all_zero_next", 64'({pm[0][4], pm[1][4], pm[2][4], pm[3][4],
                                  bm[0][4], bm[1][4], bm[2][4], bm[3][4],
                                  dm[0][4], dm[1][4], dm[2][4], dm[3][4]}), 64'h0);

    // Restart in the done cycle, plus an ignored start while busy.
    set_cfg(0, 2, 2);
    run(12, 64'h51, 4'b0001, -1, 0, -1, '0, -1);
    chk("b2b_pulses", pm[0], 64'hAA);
    chk("b2b_done",   dm[0], 64'h110);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pulse_train_gen.md
PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 Parameter CH_NUM, default 4, number of independent pulse channels.
REQ-002 Parameter CNT_W, default 16, width of pulse-count request and internal count.
REQ-003 Parameter PER_W, default 8, width of pulse-period request.
REQ-004 i_clk  input  1  single clock; all logic on rising edge.
REQ-005 i_rst  input  1  synchronous, active-high reset.
REQ-006 i_en  input  1  global enable; low pauses all channels.
REQ-007 i_start  input  CH_NUM  per-channel start request, 1-cycle level sample.
REQ-008 i_stop  input  CH_NUM  per-channel abort request.
REQ-009 i_pulse_num  input  CH_NUM*CNT_W  per-channel pulse count N; channel k occupies bits [k*CNT_W +: CNT_W].
REQ-010 i_period  input  CH_NUM*PER_W  per-channel period P in clocks, same packing.
REQ-011 o_pulse  output  CH_NUM  registered pulse train, 1-cycle-high pulses.
REQ-012 o_busy  output  CH_NUM  channel is emitting a train.
REQ-013 o_done  output  CH_NUM  1-cycle strobe on normal train completion.

Function
REQ-014 Each channel shall run an independent FSM with states IDLE, HIGH, LOW.
REQ-015 In IDLE, the channel shall accept a start when i_start[k]=1, i_en=1, and N!=0; it shall latch N and the effective period, then enter HIGH next cycle.
REQ-016 A start with N=0, or with i_en=0, shall be ignored (no busy, no done).
REQ-017 Effective period shall be max(P,2); P of 0 or 1 is clamped to 2.
REQ-018 o_pulse shall be 1 exactly in HIGH cycles; each HIGH lasts 1 cycle, followed by P-1 LOW cycles, except after the last pulse.
REQ-019 For a start sampled at cycle T with i_en held high, pulses shall occur at T+1+i*P for i=0..N-1.
REQ-020 After the N-th HIGH, the FSM shall return to IDLE; o_done shall be 1 for exactly the following cycle (T+2+(N-1)*P).
REQ-021 o_busy shall be 1 from T+1 through the last HIGH cycle inclusive, and 0 in the o_done cycle.
REQ-022 i_start while busy shall be ignored; no queuing.
REQ-023 Start may be accepted in the same cycle o_done is high (back-to-back trains).
REQ-024 i_stop[k]=1 shall force channel k to IDLE at the next edge, with o_pulse=0 and no o_done; stop has priority over start and over normal progression.
REQ-025 While i_en=0, all state, pulse and gap counters shall hold, and o_pulse shall be 0; a HIGH interrupted by i_en=0 shall be emitted when i_en returns, so total pulse count stays N.
REQ-026 Pulse and gap counters shall not wrap; N up to 2^CNT_W-1 and P up to 2^PER_W-1 shall be exact.
REQ-027 Changes to i_pulse_num or i_period during a train shall not affect it (latched values only).

Reset
REQ-028 On i_rst=1 at a clock edge, all channels shall go to IDLE, counters shall clear, and o_pulse, o_busy, and o_done shall be 0 at the next edge.
REQ-029 Reset mid-train shall abort it without o_done; reset shall override stop, start and en.

Structure
REQ-030 CH_NUM, CNT_W, PER_W defaults and the FSM state encoding (IDLE/HIGH/LOW) shall live in a shared package.
REQ-031 The per-channel logic shall be a sub-module pulse_emitter, instantiated CH_NUM times via a generate loop; the top shall only slice buses.

Verification
REQ-032 ch0 N=3, P=4, start at T -> o_pulse[0] high at T+1, T+5, T+9; o_done[0] at T+10; busy T+1..T+9.
REQ-033 N=0 start -> no pulse, busy, or done; P=0 with N=2 -> pulses 2 cycles apart.
REQ-034 All four channels started same cycle with N=1,2,3,4, P=3 -> correct independent trains; each output looped into the team's pulse counter reads 1,2,3,4.
REQ-035 i_en low 5 cycles during the 2nd gap of N=3, P=4 -> timeline shifted by 5, still 3 pulses, done once.
REQ-036 i_stop after 2nd pulse of N=5 -> no further pulses, no done; i_rst mid-train -> all outputs 0 next cycle.
REQ-037 Restart in done cycle, and a start while busy -> the second train runs fully, and the busy-start is ignored.
